start_text_renderer: RTL

//  Downstream consumer of the start-screen glyph ROM (14 chars x 16 rows x 8 bits, addr = {char[6:0],row[3:0]}).

---
 rtl/start_text_renderer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/start_text_renderer.sv
// start_text_renderer: start-screen text overlay and start-screen FSM.
//  - Maps DrawX/DrawY onto glyph ROM addresses (addr = {char, row}), registers
//    the returned row byte lane and emits text_on two Clk after each pixel.
//  - Blinks the prompt every BLINK_FRAMES frames, acknowledges a start_key
//    rising edge with ACK_FRAMES of solid text, then pulses game_start.
//  - Build option START_TEXT_SCALE2_EN: draws glyphs at 2x (16x32 px cells).
//    Without it the text is drawn at 1x (8x16 px cells). FSM and pipeline
//    timing are identical in both builds.
//  - dbg_state exposes the FSM state (0 = BLINK, 1 = ACK, 2 = DONE).
module start_text_renderer #(
  parameter int TEXT_X       = 264,
  parameter int TEXT_Y       = 232,
  parameter int NUM_CHARS    = 14,
  parameter int BLINK_FRAMES = 30,
  parameter int ACK_FRAMES   = 60
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        VS,
  input  logic        start_key,
  input  logic        show_req,
  input  logic [7:0]  rom_data,
  output logic [10:0] rom_addr,
  output logic        text_on,
  output logic        game_start,
  output logic        screen_active,
  output logic [1:0]  dbg_state
);

`ifdef START_TEXT_SCALE2_EN
  localparam int CELL_W = 16;
  localparam int WIN_H  = 32;
`else
  localparam int CELL_W = 8;
  localparam int WIN_H  = 16;
`endif
  localparam int WIN_W = CELL_W * NUM_CHARS;

  localparam logic [10:0] X_LO = 11'(TEXT_X);
  localparam logic [10:0] X_HI = 11'(TEXT_X + WIN_W);
  localparam logic [10:0] Y_LO = 11'(TEXT_Y);
  localparam logic [10:0] Y_HI = 11'(TEXT_Y + WIN_H);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] ACK_LAST   = 8'(ACK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_BLINK = 2'd0,
    ST_ACK   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // FSM registers
  state_t      state_q, state_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  ack_cnt_q, ack_cnt_d;
  logic        game_start_q, game_start_d;
  logic        screen_active_q, screen_active_d;
  logic        vs_q, start_key_q;

  // Pixel pipeline registers
  logic [10:0] rom_addr_q, rom_addr_d;
  logic [2:0]  pix_col_q, pix_col_d;
  logic        win_q, win_d;
  logic        vis_q, vis_d;
  logic        text_on_q, text_on_d;

  logic [9:0]  dx, dy;
  logic        in_win;
  logic        frame_tick, key_rise;
  logic        unused_bits;

  assign frame_tick = vs_q & ~VS;
  assign key_rise   = start_key & ~start_key_q;

  // Window test first, then derive cell/row/column only for in-window pixels.
  always_comb begin
    in_win = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
             ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI) &&
             (DrawX <= 10'd639) && (DrawY <= 10'd479);
    dx = DrawX - 10'(TEXT_X);
    dy = DrawY - 10'(TEXT_Y);
    rom_addr_d = '0;
    pix_col_d  = '0;
    if (in_win) begin
`ifdef START_TEXT_SCALE2_EN
      rom_addr_d = {1'b0, dx[9:4], dy[4:1]};
      pix_col_d  = dx[3:1];
`else
      rom_addr_d = {dx[9:3], dy[3:0]};
      pix_col_d  = dx[2:0];
`endif
    end
    win_d     = in_win;
    vis_d     = ((state_q == ST_BLINK) && blink_phase_q) || (state_q == ST_ACK);
    text_on_d = win_q & vis_q & rom_data[3'd7 - pix_col_q];
  end

`ifdef START_TEXT_SCALE2_EN
  assign unused_bits = ^{dx[0], dy[9:5], dy[0]};
`else
  assign unused_bits = ^{dy[9:4]};
`endif

  // Two-stage pixel pipeline: address/column/visibility, then bit select.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom_addr_q <= '0;
      pix_col_q  <= '0;
      win_q      <= 1'b0;
      vis_q      <= 1'b0;
      text_on_q  <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      pix_col_q  <= pix_col_d;
      win_q      <= win_d;
      vis_q      <= vis_d;
      text_on_q  <= text_on_d;
    end
  end

  // Next-state logic: a start_key edge in BLINK takes priority over the
  // blink counter, so a coincident frame_tick leaves the blink state alone.
  always_comb begin
    state_d       = state_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    ack_cnt_d     = ack_cnt_q;
    game_start_d  = 1'b0;
    case (state_q)
      ST_BLINK: begin
        if (key_rise) begin
          state_d   = ST_ACK;
          ack_cnt_d = '0;
        end else if (frame_tick) begin
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
          end
        end
      end
      ST_ACK: begin
        if (frame_tick) begin
          if (ack_cnt_q == ACK_LAST) begin
            state_d      = ST_DONE;
            game_start_d = 1'b1;
          end else begin
            ack_cnt_d = ack_cnt_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        if (show_req) begin
          state_d       = ST_BLINK;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_BLINK;
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
      end
    endcase
    screen_active_d = (state_d != ST_DONE);
  end

  // FSM state, counters, input edge history and registered FSM outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q         <= ST_BLINK;
      blink_cnt_q     <= '0;
      blink_phase_q   <= 1'b1;
      ack_cnt_q       <= '0;
      game_start_q    <= 1'b0;
      screen_active_q <= 1'b0;
      vs_q            <= 1'b1;
      start_key_q     <= 1'b1;
    end else begin
      state_q         <= state_d;
      blink_cnt_q     <= blink_cnt_d;
      blink_phase_q   <= blink_phase_d;
      ack_cnt_q       <= ack_cnt_d;
      game_start_q    <= game_start_d;
      screen_active_q <= screen_active_d;
      vs_q            <= VS;
      start_key_q     <= start_key;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign text_on       = text_on_q;
  assign game_start    = game_start_q;
  assign screen_active = screen_active_q;
  assign dbg_state     = state_q;

endmodule
